// File: rtl/spi_master_if.sv
// Bus bundle between the SPI frame master and its user/slave side.
// The master modport is the view used by spi_master itself.
interface spi_master_if;
    logic       start;
    logic [9:0] cmd_data;
    logic       miso;
    logic       ss_n;
    logic       mosi;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        input  start, cmd_data, miso,
        output ss_n, mosi, busy, done, rd_data, rd_valid
    );

    modport slave (
        output start, cmd_data, miso,
        input  ss_n, mosi, busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_master.sv
// SPI frame master: 10-bit command frames, optional turnaround and 8-bit read-back.
// Optional frame counter output enabled by macro SPI_MASTER_FRAME_CNT_EN.
module spi_master #(
    parameter int RD_WAIT  = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.master bus
`ifdef SPI_MASTER_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [3:0] GAP_LAST  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [2:0] state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [9:0] sr_r, sr_s;
    logic [1:0] op_r, op_s;
    logic [7:0] rx_r, rx_s;
    logic [7:0] rd_data_r, rd_data_s;
    logic       ss_n_r, ss_n_s;
    logic       mosi_r, mosi_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       rd_valid_r, rd_valid_s;

    // Next-state, datapath and next-output decode; outputs are registered from the next state.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + 4'd1;
        sr_s      = sr_r;
        op_s      = op_r;
        rx_s      = rx_r;
        rd_data_s = rd_data_r;
        mosi_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 4'd0;
                if (bus.start) begin
                    sr_s    = bus.cmd_data;
                    op_s    = bus.cmd_data[9:8];
                    mosi_s  = bus.cmd_data[9];
                    state_s = ST_SEL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                cnt_s   = 4'd0;
                mosi_s  = sr_r[9];
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_r == 4'd9) begin
                    cnt_s   = 4'd0;
                    state_s = ST_HOLD;
                end else begin
                    // sr_r[9] is on the line now, so the next bit is sr_r[8]
                    mosi_s = sr_r[8];
                    sr_s   = {sr_r[8:0], 1'b0};
                end
            end
            ST_HOLD: begin
                cnt_s = 4'd0;
                if (op_r == OP_RD_DATA) begin
                    state_s = (RD_WAIT == 0) ? ST_READ : ST_WAIT;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    cnt_s   = 4'd0;
                    state_s = ST_READ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_READ: begin
                rx_s = {rx_r[6:0], bus.miso};
                if (cnt_r == 4'd7) begin
                    cnt_s     = 4'd0;
                    rd_data_s = {rx_r[6:0], bus.miso};
                    state_s   = ST_GAP;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s   = 4'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = ST_IDLE;
            end
        endcase

        ss_n_s     = (state_s == ST_IDLE) || (state_s == ST_GAP);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_GAP) && (state_r != ST_GAP);
        rd_valid_s = done_s && (op_r == OP_RD_DATA);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            sr_r       <= 10'd0;
            op_r       <= 2'd0;
            rx_r       <= 8'd0;
            rd_data_r  <= 8'd0;
            ss_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            sr_r       <= sr_s;
            op_r       <= op_s;
            rx_r       <= rx_s;
            rd_data_r  <= rd_data_s;
            ss_n_r     <= ss_n_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rd_valid_r <= rd_valid_s;
        end
    end

    assign bus.ss_n     = ss_n_r;
    assign bus.mosi     = mosi_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;

`ifdef SPI_MASTER_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if (done_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: frame-level reference model, behavioural SPI slave with RAM,
// and directed frames with hand-computed literal expectations.
module tb_spi_master;

    localparam int RW = 2;
    localparam int IG = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    spi_master_if bus();
`ifdef SPI_MASTER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    spi_master #(.RD_WAIT(RW), .IDLE_GAP(IG)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef SPI_MASTER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave with 256-byte RAM ----------------
    logic [7:0]  ram [256];
    logic [7:0]  s_addr = 8'h00;
    logic [11:0] bits = 12'h000;
    logic [11:0] last_bits = 12'h000;
    int          k = 0;
    int          last_low_len = 0;
    int          hi_run = 0;
    int          last_hi_run = 0;
    logic        in_frame = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0;
            in_frame = 1'b0;
            bus.miso = 1'b0;
        end else if (bus.ss_n == 1'b0) begin
            if (!in_frame) begin
                last_hi_run = hi_run;
                in_frame = 1'b1;
            end
            hi_run = 0;
            if (k < 12) bits = {bits[10:0], bus.mosi};
            if (k >= 12 + RW && k <= 19 + RW && bits[10:9] == 2'b11)
                bus.miso = ram[s_addr][3'(19 + RW - k)];
            else
                bus.miso = 1'b0;
            k++;
        end else begin
            hi_run++;
            bus.miso = 1'b0;
            if (in_frame) begin
                last_low_len = k;
                last_bits = bits;
                case (bits[10:9])
                    2'b00:   s_addr = bits[8:1];
                    2'b01:   ram[s_addr] = bits[8:1];
                    2'b10:   s_addr = bits[8:1];
                    default: ;
                endcase
                in_frame = 1'b0;
                k = 0;
            end
        end
    end

    // ---------------- frame-level reference model ----------------
    typedef struct packed {
        logic       ss_n;
        logic       mosi;
        logic       mchk;
        logic       busy;
        logic       done;
        logic       rv;
        logic [7:0] rd;
    } exp_t;

    exp_t q[$];
    logic [7:0] model_rd = 8'h00;

    task automatic push_frame(input logic [9:0] c);
        exp_t e;
        logic rd_frame;
        rd_frame = (c[9:8] == 2'b11);
        e.ss_n = 1'b0; e.mosi = c[9]; e.mchk = 1'b1; e.busy = 1'b1;
        e.done = 1'b0; e.rv = 1'b0; e.rd = 8'h00;
        q.push_back(e);
        for (int i = 9; i >= 0; i--) begin
            e.mosi = c[i];
            q.push_back(e);
        end
        e.mosi = 1'b0;
        q.push_back(e);
        if (rd_frame) begin
            for (int i = 0; i < RW; i++) q.push_back(e);
            e.mchk = 1'b0;
            for (int i = 0; i < 8; i++) q.push_back(e);
        end
        for (int i = 0; i < IG; i++) begin
            e.ss_n = 1'b1; e.mosi = 1'b0; e.mchk = 1'b1;
            e.done = (i == 0);
            e.rv   = (i == 0) && rd_frame;
            e.rd   = ram[s_addr];
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (bus.start) push_frame(bus.cmd_data);
        end else begin
            void'(q.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        exp_t e;
        if (q.size() > 0) begin
            e = q[0];
        end else begin
            e.ss_n = 1'b1; e.mosi = 1'b0; e.mchk = 1'b1; e.busy = 1'b0;
            e.done = 1'b0; e.rv = 1'b0; e.rd = 8'h00;
        end
        if (!rst_n) model_rd = 8'h00;
        else if (e.rv) model_rd = e.rd;
        chk("ss_n", {15'd0, bus.ss_n}, {15'd0, e.ss_n});
        chk("busy", {15'd0, bus.busy}, {15'd0, e.busy});
        chk("done", {15'd0, bus.done}, {15'd0, e.done});
        chk("rd_valid", {15'd0, bus.rd_valid}, {15'd0, e.rv});
        chk("rd_data", {8'd0, bus.rd_data}, {8'd0, model_rd});
        if (e.mchk) chk("mosi", {15'd0, bus.mosi}, {15'd0, e.mosi});
        if (bus.done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_dones(input int tgt);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt >= tgt) break;
        end
        chk("done_timeout", {15'd0, done_cnt >= tgt}, 16'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [9:0] c);
        int tgt;
        tgt = done_cnt + 1;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.cmd_data = c;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.cmd_data = ~c;
        wait_dones(tgt);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        bus.start = 1'b0;
        bus.cmd_data = 10'h000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ss_n", {15'd0, bus.ss_n}, 16'd1);
        chk("rst_mosi", {15'd0, bus.mosi}, 16'd0);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_rd_data", {8'd0, bus.rd_data}, 16'd0);
        rst_n = 1'b1;

        // write addr 0xA5
        send(10'h0A5);
        chk("wa_low_len", 16'(last_low_len), 16'd12);
        chk("wa_bits", {4'd0, last_bits}, 16'h014A);
        chk("wa_rd_data", {8'd0, bus.rd_data}, 16'd0);

        // write data 0xC3, then read data back with RD_WAIT turnaround
        send(10'h1C3);
        send(10'h3FF);
        chk("rd_low_len", 16'(last_low_len), 16'd22);
        chk("rd_c3", {8'd0, bus.rd_data}, 16'h00C3);

        // second start 3 cycles into a frame must be ignored
        base = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.cmd_data = 10'h011;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.cmd_data = 10'h2EE;
        repeat (3) @(posedge clk);
        #2;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_dones(base + 1);
        repeat (20) @(posedge clk);
        #2;
        chk("ignore_one_done", 16'(done_cnt - base), 16'd1);
        chk("ignore_bits", {4'd0, last_bits}, 16'h0022);

        // reset during SHIFT bit 5 aborts the frame
        base = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.cmd_data = 10'h155;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_ss_n", {15'd0, bus.ss_n}, 16'd1);
        chk("async_busy", {15'd0, bus.busy}, 16'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("abort_no_done", 16'(done_cnt - base), 16'd0);
        send(10'h1E1);
        chk("post_rst_bits", {4'd0, last_bits}, 16'h03C2);
        chk("post_rst_len", 16'(last_low_len), 16'd12);

        // start held high: three back-to-back read-data frames
        base = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.cmd_data = 10'h3FF;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt >= base + 3) break;
        end
        #2;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("b2b_dones", 16'(done_cnt - base), 16'd3);
        chk("b2b_gap", 16'(last_hi_run), 16'(IG + 1));
        chk("b2b_rd", {8'd0, bus.rd_data}, 16'h00E1);
`ifdef SPI_MASTER_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, 16'(done_cnt));
`endif

        // full RAM round trip through the slave
        send(10'h010);
        send(10'h15A);
        send(10'h210);
        send(10'h300);
        chk("ram_rt", {8'd0, bus.rd_data}, 16'h005A);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter RD_WAIT, default 2, giving the turnaround cycles between the end of the read-data command and the first MISO sample (legal range 0-15).
REQ-002 The block SHALL have parameter IDLE_GAP, default 1, giving the cycles SS_n is held high after a frame before the next start is accepted (legal range 1-15).
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  frame request, sampled only while busy=0.
REQ-006 cmd_data  input  10  frame word: [9:8] opcode (00 write addr, 01 write data, 10 read addr, 11 read data), [7:0] payload.
REQ-007 MISO  input  1  serial data from slave.
REQ-008 SS_n  output  1  slave select, active-low, registered.
REQ-009 MOSI  output  1  serial data to slave, MSB first, registered.
REQ-010 busy  output  1  high from the cycle after start is accepted until the return to IDLE.
REQ-011 done  output  1  one-cycle pulse at frame end.
REQ-012 rd_data  output  8  byte captured from MISO on read-data frames.
REQ-013 rd_valid  output  1  one-cycle pulse qualifying rd_data.

Function
REQ-014 The FSM SHALL have states IDLE, SEL, SHIFT, HOLD, WAIT, READ and GAP.
REQ-015 IDLE: start=1 latches cmd_data into a 10-bit shift register and moves to SEL; otherwise stays in IDLE.
REQ-016 SEL (1 cycle): SS_n=0, MOSI=cmd[9] (command-select bit); then SHIFT.
REQ-017 SHIFT (10 cycles): SS_n=0, MOSI=cmd[9] down to cmd[0], one bit per cycle; then HOLD.
REQ-018 HOLD (1 cycle): SS_n=0, MOSI=0; next state is WAIT if opcode=11, otherwise GAP.
REQ-019 WAIT (RD_WAIT cycles; skipped when RD_WAIT=0): SS_n=0, MOSI=0; then READ.
REQ-020 READ (8 cycles): SS_n=0; MISO is shifted into rd_data MSB first on each cycle; then GAP.
REQ-021 rd_valid SHALL pulse in the first GAP cycle of a read-data frame, with rd_data stable until the next read-data frame.
REQ-022 GAP (IDLE_GAP cycles): SS_n=1, MOSI=0; done pulses in the first GAP cycle; then IDLE.
REQ-023 Latency: a write frame occupies exactly 12 cycles with SS_n low; a read-data frame occupies 20+RD_WAIT cycles with SS_n low.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing; cmd_data changes after acceptance SHALL NOT affect the frame.
REQ-025 Each phase counter SHALL be 4 bits wide and SHALL clear on every state entry; no counter wraps mid-phase.
REQ-026 start held high continuously SHALL produce back-to-back frames, each separated by exactly IDLE_GAP+1 cycles of SS_n high (GAP plus the IDLE cycle).

Reset
REQ-027 While rst_n=0 the block SHALL force state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0 and all counters to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no done and no rd_valid pulse; the first start after release SHALL begin a fresh frame.

Configuration
REQ-029 With macro SPI_MASTER_FRAME_CNT_EN defined, the block SHALL add output frame_cnt (16 bits), reset to 0, incremented on each done pulse and wrapping from 0xFFFF to 0.
REQ-030 Without SPI_MASTER_FRAME_CNT_EN, the frame_cnt port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 start with cmd_data=10'h0A5 (write addr) -> SS_n low for 12 cycles, MOSI sequence 0,0,0,1,0,1,0,0,1,0,1, then 0; done pulses once; rd_valid stays 0.
REQ-032 start with cmd_data=10'h3FF, RD_WAIT=2, slave driving MISO=8'hC3 -> SS_n low for 22 cycles; rd_data=8'hC3 with rd_valid pulsing in the same cycle as done.
REQ-033 start pulsed again 3 cycles into a frame with a different cmd_data -> no effect on the MOSI stream; exactly one done.
REQ-034 rst_n driven low at SHIFT bit 5 -> SS_n=1 asynchronously with no done; a new start after release gives a complete, correct frame.
REQ-035 start held high across 3 frames -> 3 done pulses with a gap of exactly IDLE_GAP+1 cycles between frames; with SPI_MASTER_FRAME_CNT_EN defined, frame_cnt=3.
REQ-036 Paired with the existing SPI slave and RAM: write addr 0x10, write data 0x5A, read addr 0x10, read data -> rd_data=8'h5A.
